// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM bus arbiter.
package sdram_arb_pkg;

    // Requester id field is sized for the largest supported requester count.
    localparam int unsigned MAX_REQ   = 4;
    localparam int unsigned ID_W      = $clog2(MAX_REQ);
    localparam int unsigned BEATS_W   = 4;
    localparam int unsigned MAX_BEATS = 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // One outstanding read: who issued it and how many beats it returns.
    typedef struct packed {
        logic [ID_W-1:0]    id;
        logic [BEATS_W-1:0] beats;
    } rd_tag_t;

    // Beats carried by a command: burst_len+1 for bursts, otherwise one.
    function automatic logic [BEATS_W-1:0] burst_beats(input logic burst, input logic [2:0] len);
        return burst ? ({1'b0, len} + 4'd1) : 4'd1;
    endfunction

endpackage

// File: rtl/sdram_arb_tag_fifo.sv
// In-order FIFO of outstanding read tags; head is read combinationally.
module sdram_arb_tag_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == (PW+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign head      = r_mem[r_rd_ptr];
    assign count     = r_count;
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    // Storage array, written at the tail.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/sdram_bus_arbiter.sv
// Round-robin arbiter sharing the SDRAM controller bus among NUM_REQ requesters,
// with write-burst grant locking and in-order routing of returned read beats.
module sdram_bus_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned AW      = 23,
    parameter int unsigned DW      = 16,
    parameter int unsigned MAX_RD  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_read,
    input  logic [NUM_REQ-1:0]          req_write,
    input  logic [NUM_REQ*AW-1:0]       req_addr,
    input  logic [NUM_REQ-1:0]          req_burst,
    input  logic [NUM_REQ*3-1:0]        req_burst_len,
    input  logic [NUM_REQ*DW-1:0]       req_wdata,
    input  logic [NUM_REQ*(DW/8)-1:0]   req_byteenable,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [NUM_REQ-1:0]          req_rvalid,
    output logic [DW-1:0]               req_rdata,
    output logic                        bus_read,
    output logic                        bus_write,
    output logic [AW-1:0]               bus_addr,
    output logic                        bus_burst,
    output logic [2:0]                  bus_burst_len,
    output logic [DW-1:0]               bus_wdata,
    output logic [DW/8-1:0]             bus_byteenable,
    input  logic                        bus_ready,
    input  logic                        bus_rvalid,
    input  logic [DW-1:0]               bus_rdata,
    output logic                        err_orphan
);

    localparam int unsigned BEW = DW / 8;
    localparam int unsigned GW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CW  = $clog2(MAX_RD) + 1;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [GW-1:0]       r_grant;
    logic [GW-1:0]       w_grant_nxt;
    logic [GW-1:0]       r_rr_ptr;
    logic [GW-1:0]       w_rr_ptr_nxt;
    logic [GW-1:0]       w_rr_after;
    logic [2:0]          r_wr_left;
    logic [2:0]          w_wr_left_nxt;
    logic [BEATS_W-1:0]  r_head_done;
    logic                r_err_orphan;

    logic [NUM_REQ-1:0]  w_elig;
    logic                w_found;
    logic                w_accept;
    logic                w_rd_room;

    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic                w_head_valid;
    logic                w_head_last;
    logic [CW-1:0]       w_count;
    rd_tag_t             w_push_tag;
    rd_tag_t             w_head;

    sdram_arb_tag_fifo #(
        .DEPTH (MAX_RD),
        .WIDTH ($bits(rd_tag_t))
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .din   (w_push_tag),
        .pop   (w_pop),
        .full  (w_full),
        .empty (w_empty),
        .head  (w_head),
        .count (w_count)
    );

    assign w_rd_room    = (w_count < CW'(MAX_RD));
    assign w_elig       = req_write | (req_read & {NUM_REQ{w_rd_room}});
    assign w_accept     = (bus_read | bus_write) & bus_ready;
    assign w_rr_after   = (r_grant == GW'(NUM_REQ - 1)) ? '0 : (r_grant + GW'(1));

    assign w_push       = (r_state == BUSY) & bus_read & bus_ready;
    assign w_push_tag   = '{id: ID_W'(r_grant), beats: burst_beats(bus_burst, bus_burst_len)};

    assign w_head_valid = ~w_empty;
    assign w_head_last  = ((r_head_done + 4'd1) == w_head.beats);
    assign w_pop        = bus_rvalid & w_head_valid & w_head_last;

    assign req_rdata    = bus_rdata;
    assign err_orphan   = r_err_orphan;

    // A read only reaches the bus while a tag slot is free, so the push never overflows.
    assert property (@(posedge clk) disable iff (rst) w_push |-> (!w_full || w_pop));

    // Bus request mux: granted requester's command in BUSY, all zero in IDLE.
    always_comb begin
        bus_read       = 1'b0;
        bus_write      = 1'b0;
        bus_addr       = '0;
        bus_burst      = 1'b0;
        bus_burst_len  = '0;
        bus_wdata      = '0;
        bus_byteenable = '0;
        req_ready      = '0;
        if (r_state == BUSY) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (GW'(i) == r_grant) begin
                    bus_read       = req_read[i];
                    bus_write      = req_write[i];
                    bus_addr       = req_addr[i*AW +: AW];
                    bus_burst      = req_burst[i];
                    bus_burst_len  = req_burst_len[i*3 +: 3];
                    bus_wdata      = req_wdata[i*DW +: DW];
                    bus_byteenable = req_byteenable[i*BEW +: BEW];
                    req_ready[i]   = bus_ready;
                end
            end
        end
    end

    // Read-beat routing to the requester at the head of the tag FIFO.
    always_comb begin
        req_rvalid = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (bus_rvalid && w_head_valid && (w_head.id == ID_W'(i))) begin
                req_rvalid[i] = 1'b1;
            end
        end
    end

    // Next-state logic: circular search from rr_ptr in IDLE, command/burst tracking in BUSY.
    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_rr_ptr_nxt  = r_rr_ptr;
        w_wr_left_nxt = r_wr_left;
        w_found       = 1'b0;
        case (r_state)
            IDLE: begin
                // First pass covers rr_ptr..NUM_REQ-1, second pass wraps to the low indices.
                for (int unsigned i = 0; i < NUM_REQ; i++) begin
                    if (!w_found && (GW'(i) >= r_rr_ptr) && w_elig[i]) begin
                        w_found     = 1'b1;
                        w_grant_nxt = GW'(i);
                    end
                end
                for (int unsigned i = 0; i < NUM_REQ; i++) begin
                    if (!w_found && w_elig[i]) begin
                        w_found     = 1'b1;
                        w_grant_nxt = GW'(i);
                    end
                end
                if (w_found) begin
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (r_wr_left != '0) begin
                    // Burst write in progress: grant stays locked until the last beat.
                    if (bus_write && bus_ready) begin
                        w_wr_left_nxt = r_wr_left - 3'd1;
                        if (r_wr_left == 3'd1) begin
                            w_state_nxt  = IDLE;
                            w_rr_ptr_nxt = w_rr_after;
                        end
                    end
                end else if (w_accept) begin
                    if (!bus_read && bus_burst && (bus_burst_len != 3'd0)) begin
                        w_wr_left_nxt = bus_burst_len;
                    end else begin
                        w_state_nxt  = IDLE;
                        w_rr_ptr_nxt = w_rr_after;
                    end
                end else if (!bus_read && !bus_write) begin
                    w_state_nxt  = IDLE;
                    w_rr_ptr_nxt = w_rr_after;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM, grant, round-robin pointer and write-burst counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_grant   <= '0;
            r_rr_ptr  <= '0;
            r_wr_left <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_rr_ptr  <= w_rr_ptr_nxt;
            r_wr_left <= w_wr_left_nxt;
        end
    end

    // Head beat counter and sticky orphan-beat flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head_done  <= '0;
            r_err_orphan <= 1'b0;
        end else if (bus_rvalid) begin
            if (!w_head_valid) begin
                r_err_orphan <= 1'b1;
            end else if (w_head_last) begin
                r_head_done <= '0;
            end else begin
                r_head_done <= r_head_done + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_sdram_bus_arbiter.sv
// Directed self-checking bench for sdram_bus_arbiter (NUM_REQ=2, AW=23, DW=16, MAX_RD=4).
module tb_sdram_bus_arbiter;

    localparam int NUM_REQ = 2;
    localparam int AW      = 23;
    localparam int DW      = 16;
    localparam int BEW     = 2;

    logic                      clk;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_read;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*AW-1:0]     req_addr;
    logic [NUM_REQ-1:0]        req_burst;
    logic [NUM_REQ*3-1:0]      req_burst_len;
    logic [NUM_REQ*DW-1:0]     req_wdata;
    logic [NUM_REQ*BEW-1:0]    req_byteenable;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        req_rvalid;
    logic [DW-1:0]             req_rdata;
    logic                      bus_read;
    logic                      bus_write;
    logic [AW-1:0]             bus_addr;
    logic                      bus_burst;
    logic [2:0]                bus_burst_len;
    logic [DW-1:0]             bus_wdata;
    logic [BEW-1:0]            bus_byteenable;
    logic                      bus_ready;
    logic                      bus_rvalid;
    logic [DW-1:0]             bus_rdata;
    logic                      err_orphan;

    int n_pass;
    int n_total;

    sdram_bus_arbiter #(
        .NUM_REQ (2),
        .AW      (23),
        .DW      (16),
        .MAX_RD  (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_read       (req_read),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_burst      (req_burst),
        .req_burst_len  (req_burst_len),
        .req_wdata      (req_wdata),
        .req_byteenable (req_byteenable),
        .req_ready      (req_ready),
        .req_rvalid     (req_rvalid),
        .req_rdata      (req_rdata),
        .bus_read       (bus_read),
        .bus_write      (bus_write),
        .bus_addr       (bus_addr),
        .bus_burst      (bus_burst),
        .bus_burst_len  (bus_burst_len),
        .bus_wdata      (bus_wdata),
        .bus_byteenable (bus_byteenable),
        .bus_ready      (bus_ready),
        .bus_rvalid     (bus_rvalid),
        .bus_rdata      (bus_rdata),
        .err_orphan     (err_orphan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1);
    end

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_all;
        req_read       = '0;
        req_write      = '0;
        req_addr       = '0;
        req_burst      = '0;
        req_burst_len  = '0;
        req_wdata      = '0;
        req_byteenable = '0;
        bus_ready      = 1'b0;
        bus_rvalid     = 1'b0;
        bus_rdata      = '0;
    endtask

    task automatic set_req(input int i, input logic rd, input logic wr, input logic [AW-1:0] addr,
                           input logic burst, input logic [2:0] len, input logic [DW-1:0] wd,
                           input logic [BEW-1:0] be);
        req_read[i]                  = rd;
        req_write[i]                 = wr;
        req_addr[i*AW +: AW]         = addr;
        req_burst[i]                 = burst;
        req_burst_len[i*3 +: 3]      = len;
        req_wdata[i*DW +: DW]        = wd;
        req_byteenable[i*BEW +: BEW] = be;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        clear_all();
        cyc();
        n_total++;
        if ({bus_read, bus_write, bus_addr, bus_burst, bus_burst_len, bus_wdata, bus_byteenable,
             req_ready, req_rvalid, err_orphan} !== 52'd0)
            $display("FAIL reset_outputs: got %h want 0", {bus_read, bus_write, bus_addr, bus_burst,
                     bus_burst_len, bus_wdata, bus_byteenable, req_ready, req_rvalid, err_orphan});
        else n_pass++;
        bus_rdata = 16'h5A5A;
        #1;
        n_total++;
        if (req_rdata !== 16'h5A5A) $display("FAIL rdata_passthru: got %h want 5a5a", req_rdata);
        else n_pass++;
        bus_rdata = '0;
        rst = 1'b0;
    endtask

    task automatic test_round_robin;
        logic [AW-1:0]  ea;
        logic [DW-1:0]  ed;
        logic [BEW-1:0] eb;
        logic [1:0]     er;
        set_req(0, 1'b0, 1'b1, 23'h000100, 1'b0, 3'd0, 16'hA0A0, 2'b11);
        set_req(1, 1'b0, 1'b1, 23'h000200, 1'b0, 3'd0, 16'hB1B1, 2'b01);
        bus_ready = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            ea = (k % 2 == 0) ? 23'h000100 : 23'h000200;
            ed = (k % 2 == 0) ? 16'hA0A0 : 16'hB1B1;
            eb = (k % 2 == 0) ? 2'b11 : 2'b01;
            er = (k % 2 == 0) ? 2'b01 : 2'b10;
            n_total++;
            if ({bus_write, req_ready} !== 3'b000)
                $display("FAIL rr_idle_gap[%0d]: got %b want 000", k, {bus_write, req_ready});
            else n_pass++;
            cyc();
            n_total++;
            if ({bus_write, bus_addr, bus_wdata, bus_byteenable, req_ready} !== {1'b1, ea, ed, eb, er})
                $display("FAIL rr_grant[%0d]: got w=%b a=%h d=%h be=%b rdy=%b want w=1 a=%h d=%h be=%b rdy=%b",
                         k, bus_write, bus_addr, bus_wdata, bus_byteenable, req_ready, ea, ed, eb, er);
            else n_pass++;
            cyc();
        end
        clear_all();
    endtask

    task automatic test_reset_mid_busy;
        set_req(0, 1'b0, 1'b1, 23'h000010, 1'b0, 3'd0, 16'h0101, 2'b11);
        bus_ready = 1'b1;
        cyc();
        n_total++;
        if ({bus_write, req_ready} !== 3'b101)
            $display("FAIL pre_grant0: got %b want 101", {bus_write, req_ready});
        else n_pass++;
        cyc();
        set_req(1, 1'b0, 1'b1, 23'h000020, 1'b1, 3'd3, 16'h0202, 2'b11);
        bus_ready = 1'b0;
        cyc();
        n_total++;
        if ({bus_write, bus_burst, bus_burst_len, bus_addr, req_ready} !== {1'b1, 1'b1, 3'd3, 23'h000020, 2'b00})
            $display("FAIL pre_grant1: got w=%b b=%b l=%0d a=%h rdy=%b want w=1 b=1 l=3 a=000020 rdy=00",
                     bus_write, bus_burst, bus_burst_len, bus_addr, req_ready);
        else n_pass++;
        bus_ready = 1'b1;
        #1;
        n_total++;
        if (req_ready !== 2'b10) $display("FAIL pre_ready1: got %b want 10", req_ready);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_total++;
        if ({bus_read, bus_write, bus_addr, bus_burst, bus_burst_len, bus_wdata, bus_byteenable, req_ready} !== 49'd0)
            $display("FAIL reset_async: got %h want 0", {bus_read, bus_write, bus_addr, bus_burst,
                     bus_burst_len, bus_wdata, bus_byteenable, req_ready});
        else n_pass++;
        cyc();
        n_total++;
        if ({bus_write, bus_burst, req_ready} !== 4'b0000)
            $display("FAIL reset_edge: got %b want 0000", {bus_write, bus_burst, req_ready});
        else n_pass++;
        rst = 1'b0;
        cyc();
        n_total++;
        if ({bus_write, bus_addr, req_ready} !== {1'b1, 23'h000010, 2'b01})
            $display("FAIL after_reset_grant: got w=%b a=%h rdy=%b want w=1 a=000010 rdy=01",
                     bus_write, bus_addr, req_ready);
        else n_pass++;
        cyc();
        clear_all();
    endtask

    task automatic test_burst_lock;
        logic [6:0] pat;
        pat = 7'b1011010;
        set_req(0, 1'b0, 1'b1, 23'h000030, 1'b0, 3'd0, 16'h0303, 2'b11);
        set_req(1, 1'b0, 1'b1, 23'h000040, 1'b1, 3'd3, 16'h0404, 2'b10);
        bus_ready = 1'b0;
        cyc();
        for (int j = 0; j < 7; j++) begin
            bus_ready = pat[j];
            #1;
            n_total++;
            if ({bus_write, bus_burst, bus_addr, bus_wdata, req_ready} !==
                {1'b1, 1'b1, 23'h000040, 16'h0404, (pat[j] ? 2'b10 : 2'b00)})
                $display("FAIL burst_lock[%0d]: got w=%b b=%b a=%h d=%h rdy=%b want w=1 b=1 a=000040 d=0404 rdy=%b",
                         j, bus_write, bus_burst, bus_addr, bus_wdata, req_ready, (pat[j] ? 2'b10 : 2'b00));
            else n_pass++;
            cyc();
        end
        bus_ready = 1'b1;
        #1;
        n_total++;
        if ({bus_write, req_ready} !== 3'b000)
            $display("FAIL burst_end_idle: got %b want 000", {bus_write, req_ready});
        else n_pass++;
        cyc();
        n_total++;
        if ({bus_write, bus_burst, bus_addr, req_ready} !== {1'b1, 1'b0, 23'h000030, 2'b01})
            $display("FAIL burst_then_req0: got w=%b b=%b a=%h rdy=%b want w=1 b=0 a=000030 rdy=01",
                     bus_write, bus_burst, bus_addr, req_ready);
        else n_pass++;
        cyc();
        clear_all();
    endtask

    task automatic test_read_routing;
        set_req(0, 1'b1, 1'b0, 23'h000050, 1'b1, 3'd1, 16'h0000, 2'b00);
        bus_ready = 1'b1;
        cyc();
        n_total++;
        if ({bus_read, bus_write, bus_burst, bus_burst_len, bus_addr, req_ready} !==
            {1'b1, 1'b0, 1'b1, 3'd1, 23'h000050, 2'b01})
            $display("FAIL rd_cmd0: got r=%b w=%b b=%b l=%0d a=%h rdy=%b want r=1 w=0 b=1 l=1 a=000050 rdy=01",
                     bus_read, bus_write, bus_burst, bus_burst_len, bus_addr, req_ready);
        else n_pass++;
        cyc();
        set_req(0, 1'b0, 1'b0, 23'h000000, 1'b0, 3'd0, 16'h0000, 2'b00);
        set_req(1, 1'b1, 1'b0, 23'h000060, 1'b0, 3'd0, 16'h0000, 2'b00);
        cyc();
        n_total++;
        if ({bus_read, bus_addr, req_ready} !== {1'b1, 23'h000060, 2'b10})
            $display("FAIL rd_cmd1: got r=%b a=%h rdy=%b want r=1 a=000060 rdy=10", bus_read, bus_addr, req_ready);
        else n_pass++;
        cyc();
        clear_all();
        bus_rvalid = 1'b1;
        bus_rdata  = 16'h1111;
        #1;
        n_total++;
        if ({req_rvalid, req_rdata} !== {2'b01, 16'h1111})
            $display("FAIL rd_beat0: got v=%b d=%h want v=01 d=1111", req_rvalid, req_rdata);
        else n_pass++;
        cyc();
        bus_rdata = 16'h2222;
        #1;
        n_total++;
        if ({req_rvalid, req_rdata} !== {2'b01, 16'h2222})
            $display("FAIL rd_beat1: got v=%b d=%h want v=01 d=2222", req_rvalid, req_rdata);
        else n_pass++;
        cyc();
        bus_rdata = 16'h3333;
        #1;
        n_total++;
        if ({req_rvalid, req_rdata} !== {2'b10, 16'h3333})
            $display("FAIL rd_beat2: got v=%b d=%h want v=10 d=3333", req_rvalid, req_rdata);
        else n_pass++;
        cyc();
        bus_rvalid = 1'b0;
        #1;
        n_total++;
        if ({req_rvalid, err_orphan} !== 3'b000)
            $display("FAIL rd_done: got v=%b orphan=%b want v=00 orphan=0", req_rvalid, err_orphan);
        else n_pass++;
    endtask

    task automatic test_fifo_full;
        set_req(0, 1'b1, 1'b0, 23'h000070, 1'b0, 3'd0, 16'h0000, 2'b00);
        bus_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            cyc();
            n_total++;
            if ({bus_read, req_ready} !== 3'b101)
                $display("FAIL fill_rd[%0d]: got %b want 101", n, {bus_read, req_ready});
            else n_pass++;
            cyc();
        end
        set_req(1, 1'b0, 1'b1, 23'h000080, 1'b0, 3'd0, 16'h0808, 2'b11);
        cyc();
        n_total++;
        if ({bus_read, bus_write, bus_addr, req_ready} !== {1'b0, 1'b1, 23'h000080, 2'b10})
            $display("FAIL full_wr_grant: got r=%b w=%b a=%h rdy=%b want r=0 w=1 a=000080 rdy=10",
                     bus_read, bus_write, bus_addr, req_ready);
        else n_pass++;
        cyc();
        set_req(1, 1'b0, 1'b0, 23'h000000, 1'b0, 3'd0, 16'h0000, 2'b00);
        cyc();
        n_total++;
        if ({bus_read, bus_write} !== 2'b00)
            $display("FAIL full_rd_blocked: got %b want 00", {bus_read, bus_write});
        else n_pass++;
        bus_rvalid = 1'b1;
        bus_rdata  = 16'h7777;
        #1;
        n_total++;
        if (req_rvalid !== 2'b01) $display("FAIL full_ret: got %b want 01", req_rvalid);
        else n_pass++;
        cyc();
        bus_rvalid = 1'b0;
        #1;
        n_total++;
        if (bus_read !== 1'b0) $display("FAIL full_pop_cycle: got %b want 0", bus_read);
        else n_pass++;
        cyc();
        n_total++;
        if ({bus_read, bus_addr, req_ready} !== {1'b1, 23'h000070, 2'b01})
            $display("FAIL freed_rd_grant: got r=%b a=%h rdy=%b want r=1 a=000070 rdy=01",
                     bus_read, bus_addr, req_ready);
        else n_pass++;
        cyc();
        set_req(0, 1'b0, 1'b0, 23'h000000, 1'b0, 3'd0, 16'h0000, 2'b00);
        bus_rvalid = 1'b1;
        for (int n = 0; n < 4; n++) begin
            bus_rdata = 16'(n);
            #1;
            n_total++;
            if (req_rvalid !== 2'b01) $display("FAIL drain[%0d]: got %b want 01", n, req_rvalid);
            else n_pass++;
            cyc();
        end
        clear_all();
    endtask

    task automatic test_orphan;
        bus_rvalid = 1'b1;
        bus_rdata  = 16'hDEAD;
        #1;
        n_total++;
        if ({req_rvalid, err_orphan} !== 3'b000)
            $display("FAIL orphan_no_rvalid: got v=%b orphan=%b want v=00 orphan=0", req_rvalid, err_orphan);
        else n_pass++;
        cyc();
        bus_rvalid = 1'b0;
        #1;
        n_total++;
        if (err_orphan !== 1'b1) $display("FAIL orphan_set: got %b want 1", err_orphan);
        else n_pass++;
        cyc();
        cyc();
        n_total++;
        if (err_orphan !== 1'b1) $display("FAIL orphan_sticky: got %b want 1", err_orphan);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_total++;
        if (err_orphan !== 1'b0) $display("FAIL orphan_reset: got %b want 0", err_orphan);
        else n_pass++;
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_abandon;
        set_req(0, 1'b0, 1'b1, 23'h000090, 1'b0, 3'd0, 16'h0909, 2'b11);
        bus_ready = 1'b0;
        cyc();
        n_total++;
        if ({bus_write, req_ready} !== 3'b100)
            $display("FAIL abandon_grant: got %b want 100", {bus_write, req_ready});
        else n_pass++;
        set_req(0, 1'b0, 1'b0, 23'h000000, 1'b0, 3'd0, 16'h0000, 2'b00);
        #1;
        n_total++;
        if (bus_write !== 1'b0) $display("FAIL abandon_drop: got %b want 0", bus_write);
        else n_pass++;
        cyc();
        set_req(0, 1'b0, 1'b1, 23'h000090, 1'b0, 3'd0, 16'h0909, 2'b11);
        set_req(1, 1'b0, 1'b1, 23'h0000A0, 1'b0, 3'd0, 16'h0A0A, 2'b11);
        bus_ready = 1'b1;
        #1;
        n_total++;
        if (bus_write !== 1'b0) $display("FAIL abandon_idle: got %b want 0", bus_write);
        else n_pass++;
        cyc();
        n_total++;
        if ({bus_addr, req_ready} !== {23'h0000A0, 2'b10})
            $display("FAIL abandon_rr: got a=%h rdy=%b want a=0000a0 rdy=10", bus_addr, req_ready);
        else n_pass++;
        cyc();
        clear_all();
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b1;
        clear_all();
        test_reset();
        test_round_robin();
        test_reset_mid_busy();
        test_burst_lock();
        test_read_routing();
        test_fifo_full();
        test_orphan();
        test_abandon();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
